// File: rtl/stream_pkt_pkg.sv
// Shared definitions for the stream packet transmitter.
//   - default widths, matching the crossbar slave port this block drives
//   - FSM state encoding
//   - PTR_W: FIFO pointer width at the default depth
package stream_pkt_pkg;

  localparam int M_DATA_COUNT   = 2;
  localparam int T_DATA_WIDTH_D = 8;
  localparam int T_DEST_WIDTH_D = $clog2(M_DATA_COUNT);
  localparam int LEN_WIDTH_D    = 8;
  localparam int FIFO_DEPTH_D   = 16;
  localparam int PTR_W          = $clog2(FIFO_DEPTH_D);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    LAST = 2'd2
  } state_t;

endpackage

// File: rtl/stream_sync_fifo.sv
// Synchronous payload FIFO with registered full/empty flags and an occupancy
// output.
//   wr_data/wr_valid/wr_ready : push side; wr_ready = !full and ignores a
//                               same-cycle pop
//   rd_data                   : head word (combinational read)
//   rd_pop                    : consume the head word (ignored when empty)
//   empty, level              : status, updated on the clock edge
module stream_sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             wr_valid,
  output logic             wr_ready,
  output logic [WIDTH-1:0] rd_data,
  input  logic             rd_pop,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      level_nxt;
  logic             full, push, pop;

  assign wr_ready = !full;
  assign push     = wr_valid && !full;
  assign pop      = rd_pop && !empty;
  assign rd_data  = mem[rd_ptr];

  always_comb begin
    level_nxt = level;
    if (push && !pop)      level_nxt = level + 1'b1;
    else if (!push && pop) level_nxt = level - 1'b1;
  end

  // Flags come from the next level so they are plain flops, not decode logic.
  // Pointers wrap by overflow since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      level <= level_nxt;
      full  <= (level_nxt == (AW+1)'(DEPTH));
      empty <= (level_nxt == '0);
    end
  end

  // Storage carries no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/stream_pkt_tx.sv
// Packet transmitter for one crossbar slave port.
// Payload words are queued in a FIFO. A command (dest, len-1) frames the next
// len words into one stream packet. dest is held for the whole packet and
// last is asserted on the final beat.
//   cmd_valid/cmd_ready/cmd_dest/cmd_len : packet command, accepted in IDLE
//   wr_data/wr_valid/wr_ready            : payload push into the FIFO
//   s_data_o/s_dest_o/s_last_o/s_valid_o/s_ready_i : output stream
//   fifo_level                           : FIFO occupancy
//   busy                                 : a packet is in progress
module stream_pkt_tx
  import stream_pkt_pkg::*;
#(
  parameter int T_DATA_WIDTH = T_DATA_WIDTH_D,
  parameter int T_DEST_WIDTH = T_DEST_WIDTH_D,
  parameter int LEN_WIDTH    = LEN_WIDTH_D,
  parameter int FIFO_DEPTH   = FIFO_DEPTH_D
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [T_DEST_WIDTH-1:0]       cmd_dest,
  input  logic [LEN_WIDTH-1:0]          cmd_len,
  input  logic [T_DATA_WIDTH-1:0]       wr_data,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  output logic [T_DATA_WIDTH-1:0]       s_data_o,
  output logic [T_DEST_WIDTH-1:0]       s_dest_o,
  output logic                          s_last_o,
  output logic                          s_valid_o,
  input  logic                          s_ready_i,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          busy
);

  state_t                  state, state_nxt;
  logic [T_DEST_WIDTH-1:0] dest_q;
  logic [LEN_WIDTH-1:0]    beat_cnt;
  logic [T_DATA_WIDTH-1:0] fifo_head;
  logic                    fifo_empty;
  logic                    cmd_hs, slot_free, load, bubble, out_done;

  stream_sync_fifo #(
    .WIDTH (T_DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_data  (wr_data),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .rd_data  (fifo_head),
    .rd_pop   (load),
    .empty    (fifo_empty),
    .level    (fifo_level)
  );

  // The output register can take a new beat when it is empty or being drained.
  assign slot_free = !s_valid_o || s_ready_i;
  assign cmd_hs    = cmd_valid && cmd_ready;
  assign load      = (state == SEND) && slot_free && !fifo_empty;
  assign bubble    = (state == SEND) && slot_free && fifo_empty;
  assign out_done  = (state == LAST) && s_valid_o && s_ready_i;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_nxt = SEND;
      end
      SEND: if (load && beat_cnt == '0) state_nxt = LAST;
      LAST: if (out_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // beat_cnt counts down the remaining beats. It is compared against zero
  // rather than counting up to len+1, so a max-length command cannot overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dest_q   <= '0;
      beat_cnt <= '0;
    end else if (cmd_hs) begin
      dest_q   <= cmd_dest;
      beat_cnt <= cmd_len;
    end else if (load) begin
      beat_cnt <= beat_cnt - 1'b1;
    end
  end

  // Output register. While a beat is stalled, slot_free is low, so nothing
  // here changes until the beat is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_data_o  <= '0;
      s_dest_o  <= '0;
      s_last_o  <= 1'b0;
      s_valid_o <= 1'b0;
    end else if (load) begin
      s_data_o  <= fifo_head;
      s_dest_o  <= dest_q;
      s_last_o  <= (beat_cnt == '0);
      s_valid_o <= 1'b1;
    end else if (bubble) begin
      s_valid_o <= 1'b0;
    end else if (out_done) begin
      s_valid_o <= 1'b0;
      s_last_o  <= 1'b0;
    end
  end

endmodule
